// File: rtl/stopwatch_pkg.sv
// Shared codes for the stopwatch controller: datapath set codes, software command codes,
// FSM state encoding and the decoded action bundle.
package stopwatch_pkg;

    localparam logic [1:0] SW_HOLD  = 2'd0;
    localparam logic [1:0] SW_RUN   = 2'd1;
    localparam logic [1:0] SW_CLEAR = 2'd2;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;
    localparam logic [1:0] CMD_LAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CLEAR = 2'd3
    } sw_state_e;

    typedef struct packed {
        logic start;
        logic stop;
        logic clear;
        logic lap;
    } sw_act_t;

    function automatic logic [1:0] set_code(input sw_state_e st);
        case (st)
            ST_RUN:   set_code = SW_RUN;
            ST_CLEAR: set_code = SW_CLEAR;
            default:  set_code = SW_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability down-counter and a one-cycle
// pulse on each accepted press (releases are accepted silently).
module btn_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    always_comb begin
        accept = 1'b0;
        cnt_d  = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            accept = 1'b1;
            cnt_d  = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // A change back to the accepted level reloads the counter, so bounces restart the wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= RELOAD;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            cnt_q  <= cnt_d;
            rise_q <= accept & sync_q[1];
            if (accept) begin
                level_q <= sync_q[1];
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/lap sequencer for the stopwatch datapath: button and command merge,
// control FSM and lap capture registers.
//
//  state    | meaning
//  ---------+-----------------------------------------------------
//  ST_CLEAR | datapath zeroed (set=2), lasts one cycle, then IDLE
//  ST_IDLE  | cleared and stopped (set=0)
//  ST_RUN   | counting (set=1), lap events capture the timer
//  ST_PAUSE | stopped with time retained (set=0)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LAP_CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_ss,
    input  logic                 btn_lc,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd,
    input  logic [23:0]          timer,
    output logic [1:0]           set,
    output logic                 running,
    output logic [23:0]          lap_time,
    output logic                 lap_valid,
    output logic [LAP_CNT_W-1:0] lap_count
);

    logic ev_ss;
    logic ev_lc;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_ss),
        .rise_o (ev_ss)
    );

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_lc (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_lc),
        .rise_o (ev_lc)
    );

    sw_state_e            state_q;
    sw_state_e            state_d;
    logic [1:0]           set_q;
    logic                 running_q;
    logic [23:0]          lap_time_q;
    logic                 lap_valid_q;
    logic [LAP_CNT_W-1:0] lap_count_q;
    sw_act_t              act;
    logic                 capture;

    // Software commands own the cycle; buttons only count when no command is strobed.
    always_comb begin
        act = '0;
        if (cmd_valid) begin
            case (cmd)
                CMD_START: act.start = 1'b1;
                CMD_STOP:  act.stop  = 1'b1;
                CMD_CLEAR: act.clear = 1'b1;
                CMD_LAP:   act.lap   = 1'b1;
            endcase
        end else begin
            if (ev_ss) begin
                if (state_q == ST_RUN) act.stop  = 1'b1;
                else                   act.start = 1'b1;
            end
            if (ev_lc) begin
                if (state_q == ST_RUN) act.lap   = 1'b1;
                else                   act.clear = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_CLEAR: state_d = ST_IDLE;
            ST_IDLE, ST_PAUSE: begin
                if (act.clear)      state_d = ST_CLEAR;
                else if (act.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (act.clear)      state_d = ST_CLEAR;
                else if (act.stop)  state_d = ST_PAUSE;
                else if (act.lap)   capture = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            set_q       <= SW_CLEAR;
            running_q   <= 1'b0;
            lap_time_q  <= '0;
            lap_valid_q <= 1'b0;
            lap_count_q <= '0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_code(state_d);
            running_q   <= (state_d == ST_RUN);
            lap_valid_q <= capture;
            // Lap registers are zeroed on entry so they already read 0 while set=2.
            if (state_d == ST_CLEAR) begin
                lap_time_q  <= '0;
                lap_count_q <= '0;
            end else if (capture) begin
                lap_time_q <= timer;
                if (lap_count_q != '1) begin
                    lap_count_q <= lap_count_q + LAP_CNT_W'(1);
                end
            end
        end
    end

    assign set       = set_q;
    assign running   = running_q;
    assign lap_time  = lap_time_q;
    assign lap_valid = lap_valid_q;
    assign lap_count = lap_count_q;

endmodule
